multi_phase_detect: RTL
=======================

MULTI_PHASE_DETECT -- requirements
Module: multi_phase_detect

Interface
REQ-001 Parameter NUM_CH, default 2: number of microphone channels, legal 2..8.
REQ-002 Parameter TS_WIDTH, default 32: timestamp counter width, legal 8..32.
REQ-003 Parameter TIMEOUT, default 100000: maximum cycles from first edge to capture completion, legal 1..2^TS_WIDTH-1.
REQ-004 Parameter GLITCH_CYCLES, default 4: consecutive high samples needed to qualify an edge; legal 1..255; used only with the macro in REQ-026.
REQ-005 Port clock, input, 1: sole clock; every register is clocked on the rising edge.
REQ-006 Port sysreset, input, 1: synchronous, active-high reset.
REQ-007 Port signal_in, input, NUM_CH: asynchronous amplified microphone pulses.
REQ-008 Port arm, input, 1: single-cycle request to start a capture.
REQ-009 Port ack, input, 1: single-cycle acknowledge of a completed capture.
REQ-010 Port time_out, output, NUM_CH*TS_WIDTH: captured timestamps; channel i occupies bits [i*TS_WIDTH +: TS_WIDTH].
REQ-011 Port ch_valid, output, NUM_CH: per-channel captured flags.
REQ-012 Port first_ch, output, 3: index of the earliest channel.
REQ-013 Port busy, done and timed_out, outputs, 1 each: capture status flags.

Function
REQ-014 Free-running counter, TS_WIDTH bits:
- reset value 0; increments every cycle;
- wraps modulo 2^TS_WIDTH.
- Software takes differences modulo 2^TS_WIDTH.
REQ-015 Input path, per channel:
- 2-flop synchronizer, then a previous-value register.
- Rising edge = sync high AND previous low.
- Input first sampled high at clock edge k -> timestamp = counter value at edge k+2.
- Offset is identical on all channels.
REQ-016 State machine states:
- IDLE: busy=0, done=0.
- ARMED: busy=1.
- CAPTURING: busy=1.
- DONE: done=1, busy=0.
REQ-017 IDLE -> ARMED on arm. On entry to ARMED: ch_valid, timed_out and first_ch clear; time_out holds its old value.
REQ-018 ARMED -> CAPTURING on the first cycle with at least one edge:
- each edging channel captures the timestamp and sets its ch_valid bit;
- first_ch = lowest edging index;
- timeout counter loads 0.
REQ-019 In CAPTURING:
- each channel captures only its first edge; later edges on a valid channel are ignored.
- Simultaneous edges on several channels capture the same timestamp.
REQ-020 CAPTURING -> DONE in the cycle after ch_valid becomes all ones; timed_out=0.
REQ-021 CAPTURING -> DONE when the timeout counter reaches TIMEOUT before completion:
- timed_out=1;
- ch_valid shows the partial set;
- uncaptured time_out fields hold stale data.
REQ-022 DONE holds all outputs stable until ack:
- ack alone -> IDLE.
- ack and arm in the same cycle -> ARMED directly.
REQ-023 Edges in IDLE or DONE are ignored. arm in ARMED or CAPTURING is ignored. ack outside DONE is ignored.
REQ-024 Counter wrap during CAPTURING does not abort the capture; timestamps stay raw counter values.

Reset
REQ-025 sysreset overrides all other inputs in the same cycle, including mid-capture, and produces on the following edge:
- state IDLE, counter 0, synchronizers 0, timeout counter 0;
- time_out all 0, ch_valid 0, first_ch 0;
- busy 0, done 0, timed_out 0.

Configuration
REQ-026 Macro MULTI_PHASE_DETECT_GLITCH_FILTER_EN selects glitch qualification:
- Defined: an edge counts only after GLITCH_CYCLES consecutive high synchronized samples; the timestamp is the value from the first high sample, so the offset in REQ-015 is unchanged; shorter pulses are discarded; the per-channel run counter clears on any low sample and on reset.
- Undefined: GLITCH_CYCLES is ignored and REQ-015 applies unfiltered.

Verification
REQ-027 NUM_CH=2, arm, ch0 rises when counter=100, ch1 at 137 -> time_out {137+2,100+2}, first_ch=0, ch_valid=11, done=1, timed_out=0.
REQ-028 NUM_CH=4, ch2 and ch3 rise in the same cycle, then ch0, then ch1 -> equal ch2/ch3 timestamps, first_ch=2, done after ch1 is captured.
REQ-029 TIMEOUT=50, only ch0 pulses -> done 50 cycles after CAPTURING entry, timed_out=1, ch_valid=01.
REQ-030 TS_WIDTH=8, ch0 at counter 250, ch1 at 260 -> ch1 field=(262 mod 256)=6; ch1-ch0 mod 256=10.
REQ-031 sysreset asserted mid-CAPTURING, then arm with pulses -> all outputs 0 the cycle after reset; next capture is correct and old ch_valid bits are not retained.
REQ-032 With the macro defined, GLITCH_CYCLES=4: 3-cycle pulse on ch0 -> ignored; following 6-cycle pulse -> captured with first-high-sample timestamp.

Source files
------------

// File: rtl/multi_phase_detect.sv
// Multi-channel acoustic arrival timestamping: after arm, latch the free-running
// counter at the first rising edge on each channel and report the earliest channel.
// Optional glitch qualification when MULTI_PHASE_DETECT_GLITCH_FILTER_EN is defined.
module multi_phase_detect #(
  parameter int              NUM_CH        = 2,
  parameter int              TS_WIDTH      = 32,
  parameter longint unsigned TIMEOUT       = 100000,
  parameter int              GLITCH_CYCLES = 4
) (
  input  logic                         clock,
  input  logic                         sysreset,
  input  logic [NUM_CH-1:0]            signal_in,
  input  logic                         arm,
  input  logic                         ack,
  output logic [NUM_CH*TS_WIDTH-1:0]   time_out,
  output logic [NUM_CH-1:0]            ch_valid,
  output logic [2:0]                   first_ch,
  output logic                         busy,
  output logic                         done,
  output logic                         timed_out
);

  // Timeout fires on the edge where the timeout counter would reach TIMEOUT.
  localparam logic [TS_WIDTH-1:0] TO_LAST = TS_WIDTH'(TIMEOUT - 1);

  // Reject illegal configurations at elaboration.
  if (NUM_CH < 2 || NUM_CH > 8 || TS_WIDTH < 8 || TS_WIDTH > 32 ||
      GLITCH_CYCLES < 1 || GLITCH_CYCLES > 255 || TIMEOUT < 1) begin : g_bad_cfg
    $error("multi_phase_detect: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAP, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [TS_WIDTH-1:0]   cnt;
  logic [TS_WIDTH-1:0]   tcnt;
  logic [NUM_CH-1:0]     sync1, sync2;
  logic [NUM_CH-1:0]     hit;
  logic [TS_WIDTH-1:0]   stamp [NUM_CH];
  logic [2:0]            lowest;
  logic                  in_window;

  // Two-flop synchronizer on the asynchronous microphone inputs.
  always_ff @(posedge clock) begin
    if (sysreset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= signal_in;
      sync2 <= sync1;
    end
  end

`ifdef MULTI_PHASE_DETECT_GLITCH_FILTER_EN
  logic [7:0]          run      [NUM_CH];
  logic [TS_WIDTH-1:0] first_ts [NUM_CH];

  // Count consecutive high samples; remember the counter at the first one.
  always_ff @(posedge clock) begin
    if (sysreset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        run[i]      <= '0;
        first_ts[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!sync2[i]) begin
          run[i] <= '0;
        end else begin
          if (run[i] == 8'd0) first_ts[i] <= cnt;
          if (run[i] < 8'(GLITCH_CYCLES)) run[i] <= run[i] + 8'd1;
        end
      end
    end
  end

  // Edge qualifies on the GLITCH_CYCLES-th high sample, stamped from the first.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]   = sync2[i] && (run[i] == 8'(GLITCH_CYCLES - 1));
      stamp[i] = (run[i] == 8'd0) ? cnt : first_ts[i];
    end
  end
`else
  logic [NUM_CH-1:0] prev;

  // Previous-sample register for rising-edge detection.
  always_ff @(posedge clock) begin
    if (sysreset) prev <= '0;
    else          prev <= sync2;
  end

  // Unfiltered rising edge, stamped with the current counter.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]   = sync2[i] & ~prev[i];
      stamp[i] = cnt;
    end
  end
`endif

  // Lowest-numbered channel edging this cycle.
  always_comb begin
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) lowest = 3'(i);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (sysreset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; completion wins over a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arm) state_nxt = S_ARMED;
      S_ARMED: if (|hit) state_nxt = S_CAP;
      S_CAP:   if ((&ch_valid) || (tcnt == TO_LAST)) state_nxt = S_DONE;
      S_DONE:  if (ack) state_nxt = arm ? S_ARMED : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy      = (state == S_ARMED) || (state == S_CAP);
    done      = (state == S_DONE);
    in_window = busy;
  end

  // Timestamp counter, timeout counter and capture registers.
  always_ff @(posedge clock) begin
    if (sysreset) begin
      cnt       <= '0;
      tcnt      <= '0;
      time_out  <= '0;
      ch_valid  <= '0;
      first_ch  <= '0;
      timed_out <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (state_nxt == S_ARMED && state != S_ARMED) begin
        ch_valid  <= '0;
        first_ch  <= '0;
        timed_out <= 1'b0;
      end
      if (in_window) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (hit[i] && !ch_valid[i]) begin
            ch_valid[i]                      <= 1'b1;
            time_out[i*TS_WIDTH +: TS_WIDTH] <= stamp[i];
          end
        end
      end
      if (state == S_ARMED && |hit) begin
        first_ch <= lowest;
        tcnt     <= '0;
      end else if (state == S_CAP) begin
        tcnt <= tcnt + 1'b1;
      end
      if (state == S_CAP && state_nxt == S_DONE) timed_out <= ~(&ch_valid);
    end
  end

endmodule
